// File: rtl/alu_pkg.sv
// Shared encodings for the byte-loaded ALU: FSM stage codes and ALU operation codes.
package alu_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_A = 3'd0,
    ST_LOAD_B = 3'd1,
    ST_READY  = 3'd2,
    ST_DONE   = 3'd3
  } stage_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SLL = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational 32-bit ALU: result, zero flag and signed-overflow flag for one op.
module alu_core
  import alu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op,
  output logic [31:0] result,
  output logic        zf,
  output logic        of
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    result = 32'h0;
    of     = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOR: result = ~(a | b);
      OP_ADD: begin
        result = sum;
        of     = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      OP_SUB: begin
        result = diff;
        of     = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      OP_SLT: result = {31'h0, ($signed(a) < $signed(b))};
      OP_SLL: result = b << a[4:0];
      default: result = 32'h0;
    endcase
  end

  assign zf = (result == 32'h0);

endmodule

// File: rtl/alu_byte_loader.sv
// Loads two 32-bit operands one switch byte at a time, then executes an ALU op on a button press.
module alu_byte_loader
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  SW,
  input  logic        LOAD,
  input  logic        EXEC,
  input  logic [2:0]  ALU_OP,
  output logic [31:0] F,
  output logic        ZF,
  output logic        OF,
  output logic [2:0]  STAGE,
  output logic [1:0]  BYTE_IDX
);

  stage_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d, wr_idx;
  logic        load_prev, exec_prev;
  logic        load_pulse, exec_pulse;
  logic        a_we, b_we, res_we;
  logic [31:0] a_q, b_q, f_q;
  logic        zf_q, of_q;
  logic [31:0] alu_res;
  logic        alu_zf, alu_of;

  // Previous-value registers reset high so a button held through reset never looks like a press.
  assign load_pulse = LOAD & ~load_prev;
  assign exec_pulse = EXEC & ~exec_prev;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_idx  = idx_q;
    a_we    = 1'b0;
    b_we    = 1'b0;
    res_we  = 1'b0;
    case (state_q)
      ST_LOAD_A: if (load_pulse) begin
        a_we  = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_LOAD_B;
      end
      ST_LOAD_B: if (load_pulse) begin
        b_we  = 1'b1;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = ST_READY;
      end
      ST_READY: if (exec_pulse) begin
        res_we  = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        // EXEC has priority; a simultaneous LOAD press is dropped.
        if (exec_pulse) begin
          res_we = 1'b1;
        end else if (load_pulse) begin
          a_we    = 1'b1;
          wr_idx  = 2'd0;
          idx_d   = 2'd1;
          state_d = ST_LOAD_A;
        end
      end
      default: begin
        state_d = ST_LOAD_A;
        idx_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_LOAD_A;
      idx_q     <= 2'd0;
      load_prev <= 1'b1;
      exec_prev <= 1'b1;
      a_q       <= 32'h0;
      b_q       <= 32'h0;
      f_q       <= 32'h0;
      zf_q      <= 1'b0;
      of_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      load_prev <= LOAD;
      exec_prev <= EXEC;
      if (a_we) a_q[{wr_idx, 3'b000} +: 8] <= SW;
      if (b_we) b_q[{wr_idx, 3'b000} +: 8] <= SW;
      if (res_we) begin
        f_q  <= alu_res;
        zf_q <= alu_zf;
        of_q <= alu_of;
      end
    end
  end

  alu_core u_alu_core (
    .a      (a_q),
    .b      (b_q),
    .op     (ALU_OP),
    .result (alu_res),
    .zf     (alu_zf),
    .of     (alu_of)
  );

  assign F        = f_q;
  assign ZF       = zf_q;
  assign OF       = of_q;
  assign STAGE    = state_q;
  assign BYTE_IDX = idx_q;

endmodule
